// File: rtl/pw_pkg.sv
// Shared definitions for the Picowizard gen2 core.
// Contents:
//   state_e   - top-level FSM states (FETCH, EXEC, HALT)
//   CLS_*     - opcode class field Op[7:6]
//   ALU_*     - ALU subop {Op[5], Op[2]}
//   REG_*     - register indices for the RA/RB fields
//   op_sub()  - extracts the split subop field from an opcode
package pw_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_e;

  localparam logic [1:0] CLS_MOV = 2'b00;
  localparam logic [1:0] CLS_ALU = 2'b01;
  localparam logic [1:0] CLS_MEM = 2'b10;
  localparam logic [1:0] CLS_IMM = 2'b11;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_ADC  = 2'b01;
  localparam logic [1:0] ALU_NAND = 2'b10;
  localparam logic [1:0] ALU_XOR  = 2'b11;

  // Memory-class subops share the same {Op5, Op2} encoding
  localparam logic [1:0] MEM_LD  = 2'b00;
  localparam logic [1:0] MEM_ST  = 2'b01;
  localparam logic [1:0] MEM_JZ  = 2'b10;
  localparam logic [1:0] MEM_JAL = 2'b11;

  localparam logic [1:0] REG_A   = 2'd0;
  localparam logic [1:0] REG_B   = 2'd1;
  localparam logic [1:0] REG_C   = 2'd2;
  localparam logic [1:0] REG_SEG = 2'd3;

  function automatic logic [1:0] op_sub(input logic [7:0] op);
    return {op[5], op[2]};
  endfunction

endpackage

// File: rtl/pw_alu.sv
// Combinational ALU for the Picowizard gen2 core.
// Ports:
//   i_a, i_b  [DATA_W]  operands (RA, RB values)
//   i_sub     [2]       ALU subop (ADD/ADC/NAND/XOR)
//   i_cin     [1]       carry-in, used by ADC only
//   o_res     [DATA_W]  result
//   o_cout    [1]       carry-out; forced to 1 for the logic ops
module pw_alu
  import pw_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [1:0]        i_sub,
  input  logic              i_cin,
  output logic [DATA_W-1:0] o_res,
  output logic              o_cout
);

  logic [DATA_W:0] w_sum;

  always_comb begin
    w_sum  = '0;
    o_res  = '0;
    o_cout = 1'b1;
    case (i_sub)
      ALU_ADD: begin
        w_sum  = {1'b0, i_a} + {1'b0, i_b};
        o_res  = w_sum[DATA_W-1:0];
        o_cout = w_sum[DATA_W];
      end
      ALU_ADC: begin
        w_sum  = {1'b0, i_a} + {1'b0, i_b} + {{DATA_W{1'b0}}, i_cin};
        o_res  = w_sum[DATA_W-1:0];
        o_cout = w_sum[DATA_W];
      end
      ALU_NAND: o_res = ~(i_a & i_b);
      default:  o_res = i_a ^ i_b;
    endcase
  end

endmodule

// File: rtl/pw_core_gen2.sv
// Picowizard gen2 CPU core: registers A/B/C/SEG, FETCH/EXEC/HALT FSM,
// memory ready handshake and sticky halt on program-counter wrap.
// Optional trace outputs are enabled by defining PW_TRACE_EN.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_data_in  [DATA_W]   read data, valid when i_mem_ready=1
//   i_mem_ready           completes the active read/write this cycle
//   o_ld_mem / o_wrt_mem  read / write request
//   o_data_out [DATA_W]   write data
//   o_adr_out  [2*DATA_W] access address
//   o_halted              set after PC wrap, cleared only by reset
//   (PW_TRACE_EN) o_retire_valid, o_retire_pc, o_retire_op
// All outputs are registers. Requests for FETCH are issued the same edge
// the FSM enters FETCH; memory requests in EXEC are issued one cycle after
// entry, once the opcode is registered, which gives 2-cycle non-memory and
// 3-cycle memory instructions with no wait states.
module pw_core_gen2
  import pw_pkg::*;
#(
  parameter int                    DATA_W   = 8,
  parameter logic [2*DATA_W-1:0]   RESET_PC = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_W-1:0]     i_data_in,
  input  logic                  i_mem_ready,
  output logic                  o_ld_mem,
  output logic                  o_wrt_mem,
  output logic [DATA_W-1:0]     o_data_out,
  output logic [2*DATA_W-1:0]   o_adr_out,
  output logic                  o_halted
`ifdef PW_TRACE_EN
  ,
  output logic                  o_retire_valid,
  output logic [2*DATA_W-1:0]   o_retire_pc,
  output logic [7:0]            o_retire_op
`endif
);

  localparam int ADDR_W = 2 * DATA_W;

  state_e                   r_state, w_state_next;
  logic [3:0][DATA_W-1:0]   r_regs, w_regs_next;
  logic                     r_carry, w_carry_next;
  logic [ADDR_W-1:0]        r_pc, w_pc_next;
  logic                     r_wrap, w_wrap_next;
  logic [7:0]               r_op, w_op_next;

  logic                     r_ld_mem, w_ld_mem_next;
  logic                     r_wrt_mem, w_wrt_mem_next;
  logic [DATA_W-1:0]        r_data_out, w_data_out_next;
  logic [ADDR_W-1:0]        r_adr_out, w_adr_out_next;
  logic                     r_halted, w_halted_next;

  // Decode of the registered opcode
  logic [1:0]        w_cls, w_sub, w_ra, w_rb;
  logic [DATA_W-1:0] w_ra_val, w_rb_val;
  logic [ADDR_W-1:0] w_mem_adr;
  logic              w_req, w_accept;
  logic              w_pc_carry;
  logic [ADDR_W-1:0] w_pc_inc;
  logic              w_done, w_jump;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_alu_cout;

  assign w_cls     = r_op[7:6];
  assign w_sub     = op_sub(r_op);
  assign w_ra      = r_op[4:3];
  assign w_rb      = r_op[1:0];
  assign w_ra_val  = r_regs[w_ra];
  assign w_rb_val  = r_regs[w_rb];
  assign w_mem_adr = {r_regs[REG_SEG], w_rb_val};

  // MemReady only counts while a request is actually on the bus
  assign w_req    = r_ld_mem | r_wrt_mem;
  assign w_accept = w_req & i_mem_ready;

  assign {w_pc_carry, w_pc_inc} = {1'b0, r_pc} + (ADDR_W + 1)'(1);

  pw_alu #(.DATA_W(DATA_W)) u_alu (
    .i_a    (w_ra_val),
    .i_b    (w_rb_val),
    .i_sub  (w_sub),
    .i_cin  (r_carry),
    .o_res  (w_alu_res),
    .o_cout (w_alu_cout)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= FETCH;
    else       r_state <= w_state_next;
  end

  // Next-state and datapath update
  always_comb begin
    w_state_next = r_state;
    w_regs_next  = r_regs;
    w_carry_next = r_carry;
    w_pc_next    = r_pc;
    w_wrap_next  = r_wrap;
    w_op_next    = r_op;
    w_done       = 1'b0;
    w_jump       = 1'b0;
    case (r_state)
      FETCH: begin
        if (w_accept) begin
          w_op_next    = i_data_in[7:0];
          w_pc_next    = w_pc_inc;
          w_wrap_next  = r_wrap | w_pc_carry;
          w_state_next = EXEC;
        end
      end
      EXEC: begin
        case (w_cls)
          CLS_MOV: begin
            w_regs_next[w_ra] = w_rb_val;
            w_done = 1'b1;
          end
          CLS_ALU: begin
            w_regs_next[w_ra] = w_alu_res;
            w_carry_next = w_alu_cout;
            w_done = 1'b1;
          end
          CLS_MEM: begin
            case (w_sub)
              MEM_LD: begin
                if (w_accept) begin
                  w_regs_next[w_ra] = i_data_in;
                  w_done = 1'b1;
                end
              end
              MEM_ST: w_done = w_accept;
              MEM_JZ: begin
                if (w_ra_val == '0) begin
                  w_pc_next = w_mem_adr;
                  w_jump    = 1'b1;
                end
                w_done = 1'b1;
              end
              default: begin
                // JAL: target from pre-write RA/RB, return PC into {C,B}
                w_pc_next             = {w_ra_val, w_rb_val};
                w_regs_next[REG_C]    = r_pc[ADDR_W-1:DATA_W];
                w_regs_next[REG_B]    = r_pc[DATA_W-1:0];
                w_jump                = 1'b1;
                w_done                = 1'b1;
              end
            endcase
          end
          default: begin
            // LDI: the immediate would sit past the wrapped PC, so abort
            if (r_wrap) begin
              w_state_next = HALT;
            end else if (w_accept) begin
              w_regs_next[w_ra] = i_data_in;
              w_pc_next = w_pc_inc;
              w_done = 1'b1;
            end
          end
        endcase
        if (w_done) begin
          if (w_jump) begin
            w_wrap_next  = 1'b0;
            w_state_next = FETCH;
          end else if (r_wrap) begin
            w_state_next = HALT;
          end else begin
            w_state_next = FETCH;
          end
        end
      end
      default: w_state_next = HALT;
    endcase
  end

  // Output register next values
  always_comb begin
    w_ld_mem_next   = r_ld_mem;
    w_wrt_mem_next  = r_wrt_mem;
    w_data_out_next = r_data_out;
    w_adr_out_next  = r_adr_out;
    w_halted_next   = (w_state_next == HALT);
    case (r_state)
      FETCH: begin
        if (!w_req) begin
          w_ld_mem_next  = 1'b1;
          w_adr_out_next = r_pc;
        end else if (w_accept) begin
          w_ld_mem_next  = 1'b0;
        end
      end
      EXEC: begin
        if (w_state_next != EXEC) begin
          // Leaving EXEC: either start the next fetch or go quiet in HALT
          w_ld_mem_next  = (w_state_next == FETCH);
          w_wrt_mem_next = 1'b0;
          w_adr_out_next = w_pc_next;
        end else if (!w_req) begin
          if (w_cls == CLS_IMM) begin
            w_ld_mem_next  = 1'b1;
            w_adr_out_next = r_pc;
          end else if (w_sub == MEM_ST) begin
            w_wrt_mem_next  = 1'b1;
            w_adr_out_next  = w_mem_adr;
            w_data_out_next = w_ra_val;
          end else begin
            w_ld_mem_next  = 1'b1;
            w_adr_out_next = w_mem_adr;
          end
        end
      end
      default: begin
        w_ld_mem_next  = 1'b0;
        w_wrt_mem_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_regs     <= '0;
      r_carry    <= 1'b0;
      r_pc       <= RESET_PC;
      r_wrap     <= 1'b0;
      r_op       <= '0;
      r_ld_mem   <= 1'b0;
      r_wrt_mem  <= 1'b0;
      r_data_out <= '0;
      r_adr_out  <= '0;
      r_halted   <= 1'b0;
    end else begin
      r_regs     <= w_regs_next;
      r_carry    <= w_carry_next;
      r_pc       <= w_pc_next;
      r_wrap     <= w_wrap_next;
      r_op       <= w_op_next;
      r_ld_mem   <= w_ld_mem_next;
      r_wrt_mem  <= w_wrt_mem_next;
      r_data_out <= w_data_out_next;
      r_adr_out  <= w_adr_out_next;
      r_halted   <= w_halted_next;
    end
  end

  assign o_ld_mem   = r_ld_mem;
  assign o_wrt_mem  = r_wrt_mem;
  assign o_data_out = r_data_out;
  assign o_adr_out  = r_adr_out;
  assign o_halted   = r_halted;

`ifdef PW_TRACE_EN
  logic [ADDR_W-1:0] r_op_pc;
  logic              r_retire_valid;
  logic [ADDR_W-1:0] r_retire_pc;
  logic [7:0]        r_retire_op;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op_pc        <= '0;
      r_retire_valid <= 1'b0;
      r_retire_pc    <= '0;
      r_retire_op    <= '0;
    end else begin
      if (r_state == FETCH && w_accept) r_op_pc <= r_pc;
      r_retire_valid <= (r_state == EXEC) && w_done;
      if ((r_state == EXEC) && w_done) begin
        r_retire_pc <= r_op_pc;
        r_retire_op <= r_op;
      end
    end
  end

  assign o_retire_valid = r_retire_valid;
  assign o_retire_pc    = r_retire_pc;
  assign o_retire_op    = r_retire_op;
`endif

endmodule

// File: tb/tb_pw_core_gen2.sv
// Self-checking bench for pw_core_gen2 (DATA_W=8, default build).
// A memory responder model answers requests, inserts wait states at one
// chosen address and compares every completed access with a queue of
// expected accesses pushed when each program is loaded.
module tb_pw_core_gen2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data_in = 8'h00;
  logic        mem_ready = 1'b0;
  logic        ld, wrt, halted;
  logic [7:0]  dout;
  logic [15:0] adr;

  always #5 clk = ~clk;

  pw_core_gen2 #(.DATA_W(8), .RESET_PC(16'h0000)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_data_in   (data_in),
    .i_mem_ready (mem_ready),
    .o_ld_mem    (ld),
    .o_wrt_mem   (wrt),
    .o_data_out  (dout),
    .o_adr_out   (adr),
    .o_halted    (halted)
  );

  localparam logic [1:0] R_A = 2'd0, R_B = 2'd1, R_C = 2'd2, R_S = 2'd3;

  typedef struct {
    bit          wr;
    logic [15:0] adr;
    logic [7:0]  data;
  } acc_t;

  acc_t        exp_q[$];
  logic [7:0]  mem [0:65535];
  int          read_cyc [int];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [15:0] wait_addr = 16'h0000;
  int          wait_len = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] op_ldi(input logic [1:0] ra);
    return {2'b11, 1'b0, ra, 3'b000};
  endfunction
  function automatic logic [7:0] op_alu(input logic [1:0] s, input logic [1:0] ra, input logic [1:0] rb);
    return {2'b01, s[1], ra, s[0], rb};
  endfunction
  function automatic logic [7:0] op_mem(input logic [1:0] s, input logic [1:0] ra, input logic [1:0] rb);
    return {2'b10, s[1], ra, s[0], rb};
  endfunction
  function automatic logic [7:0] op_mov(input logic [1:0] ra, input logic [1:0] rb);
    return {2'b00, 1'b0, ra, 1'b0, rb};
  endfunction

  task automatic er(input logic [15:0] a);
    exp_q.push_back('{wr: 1'b0, adr: a, data: 8'h00});
  endtask
  task automatic ew(input logic [15:0] a, input logic [7:0] d);
    exp_q.push_back('{wr: 1'b1, adr: a, data: d});
  endtask
  task automatic er_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) er(16'(i));
  endtask

  // Memory responder: one transaction line per completed access
  int          hold_cnt = 0;
  bit          given = 0;
  bit          g_wr;
  logic [15:0] g_adr;
  logic [7:0]  g_dout;
  int          g_hold;

  always @(negedge clk) begin
    if (rst) begin
      hold_cnt  = 0;
      given     = 0;
      mem_ready = 1'b0;
    end else begin
      if (given) begin
        acc_t e;
        given = 0;
        check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          $display("[TB] cyc %0d %s adr=%04h data=%02h hold=%0d", cyc,
                   g_wr ? "WR" : "RD", g_adr, g_wr ? g_dout : mem[g_adr], g_hold);
          check("acc_kind", 32'(g_wr), 32'(e.wr));
          check("acc_adr", 32'(g_adr), 32'(e.adr));
          if (e.wr) check("acc_wdata", 32'(g_dout), 32'(e.data));
          check("acc_hold", 32'(g_hold), (g_adr == wait_addr) ? 32'(wait_len + 1) : 32'd1);
        end
        if (g_wr) mem[g_adr] = g_dout;
        else      read_cyc[int'(g_adr)] = cyc;
        hold_cnt = 0;
      end
      mem_ready = 1'b0;
      if (ld || wrt) begin
        hold_cnt++;
        if (hold_cnt == 1) begin
          g_wr = wrt; g_adr = adr; g_dout = dout;
          check("one_request", 32'({ld, wrt}), wrt ? 32'd1 : 32'd2);
        end else begin
          check("hold_stable", {14'd0, wrt, ld, adr}, {14'd0, g_wr, ~g_wr, g_adr});
          if (g_wr) check("hold_wdata", 32'(dout), 32'(g_dout));
        end
        if (hold_cnt > ((adr == wait_addr) ? wait_len : 0)) begin
          mem_ready = 1'b1;
          data_in   = mem[adr];
          given     = 1;
          g_hold    = hold_cnt;
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ctl", 32'({ld, wrt, halted}), 32'd0);
    check("reset_adr", 32'(adr), 32'd0);
    check("reset_dout", 32'(dout), 32'd0);
    rst = 1'b0;
  endtask

  task automatic wait_halt_and_drain(input string name, input int budget);
    int k;
    k = 0;
    while (!halted && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({name, "_halted"}, 32'(halted), 32'd1);
    repeat (5) begin
      @(negedge clk);
      check({name, "_quiet"}, 32'({ld, wrt}), 32'd0);
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

    // ---- Program A: arithmetic, stalled ST, JZ both ways, JAL, wrap halt
    mem[16'h0000] = op_ldi(R_A);              mem[16'h0001] = 8'h05;
    mem[16'h0002] = op_ldi(R_B);              mem[16'h0003] = 8'hFB;
    mem[16'h0004] = op_alu(2'b00, R_A, R_B);  // ADD -> A=00, carry=1
    mem[16'h0005] = op_ldi(R_S);              mem[16'h0006] = 8'h80;
    mem[16'h0007] = op_mem(2'b01, R_A, R_B);  // ST 80FB <- 00
    mem[16'h0008] = op_alu(2'b01, R_A, R_A);  // ADC -> A=01, carry=0
    mem[16'h0009] = op_mem(2'b01, R_A, R_B);  // ST 80FB <- 01
    mem[16'h000A] = op_alu(2'b01, R_A, R_A);  // ADC -> A=02
    mem[16'h000B] = op_mem(2'b01, R_A, R_B);  // ST 80FB <- 02
    mem[16'h000C] = op_ldi(R_S);              mem[16'h000D] = 8'h12;
    mem[16'h000E] = op_ldi(R_B);              mem[16'h000F] = 8'h34;
    mem[16'h0010] = op_ldi(R_A);              mem[16'h0011] = 8'h5A;
    mem[16'h0012] = op_mem(2'b01, R_A, R_B);  // ST 1234 <- 5A, stalled
    mem[16'h0013] = op_ldi(R_A);              mem[16'h0014] = 8'h00;
    mem[16'h0015] = op_ldi(R_S);              mem[16'h0016] = 8'h20;
    mem[16'h0017] = op_ldi(R_B);              mem[16'h0018] = 8'h10;
    mem[16'h0019] = op_mem(2'b10, R_A, R_B);  // JZ taken -> 2010
    mem[16'h2010] = op_ldi(R_A);              mem[16'h2011] = 8'h01;
    mem[16'h2012] = op_mem(2'b10, R_A, R_B);  // JZ not taken
    mem[16'h2013] = op_ldi(R_C);              mem[16'h2014] = 8'h03;
    mem[16'h2015] = op_ldi(R_B);              mem[16'h2016] = 8'h40;
    mem[16'h2017] = op_mem(2'b11, R_C, R_B);  // JAL -> 0340, C=20 B=18
    mem[16'h0340] = op_mem(2'b01, R_C, R_B);  // ST 2018 <- 20
    mem[16'h0341] = op_mem(2'b01, R_B, R_B);  // ST 2018 <- 18
    mem[16'h0342] = op_ldi(R_C);              mem[16'h0343] = 8'hFF;
    mem[16'h0344] = op_ldi(R_B);              mem[16'h0345] = 8'hFF;
    mem[16'h0346] = op_mem(2'b11, R_C, R_B);  // JAL -> FFFF
    mem[16'hFFFF] = op_mov(R_A, R_B);         // MOV at FFFF -> halt
    wait_addr = 16'h1234; wait_len = 3;
    er_range(16'h0000, 16'h0007); ew(16'h80FB, 8'h00);
    er_range(16'h0008, 16'h0009); ew(16'h80FB, 8'h01);
    er_range(16'h000A, 16'h000B); ew(16'h80FB, 8'h02);
    er_range(16'h000C, 16'h0012); ew(16'h1234, 8'h5A);
    er_range(16'h0013, 16'h0019);
    er_range(16'h2010, 16'h2017);
    er(16'h0340); ew(16'h2018, 8'h20);
    er(16'h0341); ew(16'h2018, 8'h18);
    er_range(16'h0342, 16'h0346);
    er(16'hFFFF);
    do_reset();
    wait_halt_and_drain("progA", 2000);
    check("lat_alu", 32'(read_cyc[5] - read_cyc[4]), 32'd2);
    check("lat_ldi", 32'(read_cyc[2] - read_cyc[0]), 32'd3);
    check("lat_st", 32'(read_cyc[8] - read_cyc[7]), 32'd3);
    check("lat_jz", 32'(read_cyc[16'h2010] - read_cyc[16'h0019]), 32'd2);

    // ---- Program B: taken JZ at FFFF clears wrap; not-taken JZ at FFFF halts
    mem[16'h0000] = op_ldi(R_C);              mem[16'h0001] = 8'hFF;
    mem[16'h0002] = op_ldi(R_B);              mem[16'h0003] = 8'hFF;
    mem[16'h0004] = op_mem(2'b11, R_C, R_B);  // JAL -> FFFF, C=00 B=05
    mem[16'hFFFF] = op_mem(2'b10, R_A, R_B);  // JZ A,B
    mem[16'h0005] = op_ldi(R_A);              mem[16'h0006] = 8'h77;
    mem[16'h0007] = op_mem(2'b01, R_A, R_B);  // ST 0005 <- 77
    mem[16'h0008] = op_ldi(R_C);              mem[16'h0009] = 8'hFF;
    mem[16'h000A] = op_ldi(R_B);              mem[16'h000B] = 8'hFF;
    mem[16'h000C] = op_mem(2'b11, R_C, R_B);  // JAL -> FFFF again
    wait_addr = 16'hFFFF; wait_len = 2;
    er_range(16'h0000, 16'h0004); er(16'hFFFF);
    er_range(16'h0005, 16'h0007); ew(16'h0005, 8'h77);
    er_range(16'h0008, 16'h000C); er(16'hFFFF);
    do_reset();
    wait_halt_and_drain("progB", 1000);

    // ---- Program C: LDI at FFFF aborts without reading the immediate
    mem[16'h0000] = op_ldi(R_C);              mem[16'h0001] = 8'hFF;
    mem[16'h0002] = op_ldi(R_B);              mem[16'h0003] = 8'hFF;
    mem[16'h0004] = op_mem(2'b11, R_C, R_B);
    mem[16'hFFFF] = op_ldi(R_A);
    wait_addr = 16'h0003; wait_len = 1;
    er_range(16'h0000, 16'h0004); er(16'hFFFF);
    do_reset();
    wait_halt_and_drain("progC", 1000);

    // ---- Program D: reset during a stalled LD
    mem[16'h0000] = op_ldi(R_S);              mem[16'h0001] = 8'hAB;
    mem[16'h0002] = op_ldi(R_B);              mem[16'h0003] = 8'hCD;
    mem[16'h0004] = op_mem(2'b00, R_A, R_B);  // LD A <- ABCD, never ready
    wait_addr = 16'hABCD; wait_len = 1000;
    er_range(16'h0000, 16'h0004);
    do_reset();
    begin
      int k;
      k = 0;
      while (!(ld && adr == 16'hABCD) && k < 100) begin
        @(negedge clk);
        k++;
      end
    end
    check("progD_ld_issued", {15'd0, ld, adr}, {15'd0, 1'b1, 16'hABCD});
    repeat (3) @(negedge clk);
    check("progD_ld_waiting", 32'({ld, wrt}), 32'd2);
    check("progD_drained", 32'(exp_q.size()), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_ctl", 32'({ld, wrt, halted}), 32'd0);
    check("midrst_adr", 32'(adr), 32'd0);
    check("midrst_dout", 32'(dout), 32'd0);
    // Registers must be zero after reset: ST A,B writes 00 to {SEG,B}=0000
    mem[16'h0000] = op_mem(2'b01, R_A, R_B);
    mem[16'h0001] = op_ldi(R_C);              mem[16'h0002] = 8'hFF;
    mem[16'h0003] = op_ldi(R_B);              mem[16'h0004] = 8'hFF;
    mem[16'h0005] = op_mem(2'b11, R_C, R_B);
    mem[16'hFFFF] = op_mov(R_A, R_B);
    exp_q.delete();
    er(16'h0000); ew(16'h0000, 8'h00);
    er_range(16'h0001, 16'h0005); er(16'hFFFF);
    rst = 1'b0;
    wait_halt_and_drain("progD", 1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pw_core_gen2.md
Name: pw_core_gen2

Overview:
- Second-generation Picowizard CPU core, width-parametrised.
- Same register model (A, B, C, SEG) and the same 8-bit opcode field layout.
- Adds an explicit FSM, a memory ready handshake for wait states, a sticky halt on program-counter wrap, and register reset.
- Sits between the system bus and program/data memory in place of the first-generation core.

Parameters:
- DATA_W, 8: register/data width; must be >= 8; opcode is fetched word bits [7:0].
- RESET_PC, 0: PC value after reset, ADDR_W bits.
- ADDR_W (localparam), 2*DATA_W: address width.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  synchronous, active-high reset.
- DataIn  in  DATA_W  read data; valid in the cycle MemReady=1.
- MemReady  in  1  completes the current LdMem/WrtMem access this cycle.
- LdMem  out  1  read request.
- WrtMem  out  1  write request.
- DataOut  out  DATA_W  write data; valid while WrtMem=1.
- AdrOut  out  ADDR_W  access address.
- Halted  out  1  core stopped after PC wrap; cleared only by Rst.

Behaviour:
Reset:
- Reset outputs: LdMem=0, WrtMem=0, DataOut=0, AdrOut=0, Halted=0.
- Reset state: A=B=C=SEG=0, Carry=0, PC=RESET_PC, WrapPend=0, state FETCH.
- Rst wins over everything, including an in-flight access; a pending access is dropped.

Opcode fields:
- Op[7:6] class; Op[5]/Op[2] subop.
- RA=Op[4:3], RB=Op[1:0]; register index 0=A, 1=B, 2=C, 3=SEG.

Classes:
- 00 MOV: RA<=RB.
- 01 ALU on {Op5,Op2}:
  - 00 ADD: {Carry,RA}<=RA+RB.
  - 01 ADC: {Carry,RA}<=RA+RB+Carry.
  - 10 NAND: RA<=~(RA&RB), Carry<=1.
  - 11 XOR: RA<=RA^RB, Carry<=1.
  - Sums are DATA_W+1 wide; Carry changes only on ALU ops.
- 10 Op5=0 Op2=0 LD: RA<=mem[{SEG,RB}].
- 10 Op5=0 Op2=1 ST: mem[{SEG,RB}]<=RA.
- 10 Op5=1 Op2=0 JZ: if RA==0, PC<={SEG,RB}.
- 10 Op5=1 Op2=1 JAL: PC<={RA,RB}; {C,B}<=return PC (already incremented).
  - Target uses pre-write register values.
- 11 LDI: RA<=word at PC; PC+=1.

FSM:
- FETCH:
  - LdMem=1, AdrOut=PC.
  - On MemReady: Op<=DataIn[7:0]; PC<=PC+1; carry-out sets WrapPend; go to EXEC.
- EXEC:
  - MOV, ALU, JZ, JAL complete in 1 cycle.
  - LD: LdMem=1, AdrOut={SEG,RB}; write RA on MemReady.
  - ST: WrtMem=1, AdrOut={SEG,RB}, DataOut=RA; done on MemReady.
  - LDI: LdMem=1, AdrOut=PC. If WrapPend=1 on entry, abort: RA unchanged, go to HALT.
- After EXEC completes: go to HALT if WrapPend=1 and no jump was taken; otherwise go to FETCH.
  - A taken JZ or JAL clears WrapPend.
- HALT: terminal. Halted=1, LdMem=WrtMem=0, AdrOut holds last PC.

Handshake:
- While MemReady=0, AdrOut, DataOut, LdMem and WrtMem hold stable and no state changes.
- MemReady is ignored when no request is active.

Latency with zero wait states:
- MOV, ALU, JZ, JAL: 2 cycles.
- LD, ST, LDI: 3 cycles.

Optional Feature:
- Macro: PW_TRACE_EN.
- When defined, adds outputs:
  - RetireValid (1): 1-cycle pulse on each instruction completion.
  - RetirePc (ADDR_W): address of the retired opcode.
  - RetireOp (8): the retired opcode.
  - Registered; reset 0.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package pw_pkg:
  - state enum {FETCH, EXEC, HALT};
  - class constants MOV/ALU/MEM/IMM;
  - ALU subop constants;
  - register index constants.
- Sub-module pw_alu: combinational (DATA_W operands, subop, carry-in) -> (result, carry-out).
- Register file, FSM and PC stay in the core.

Test Plan:
- LDI A,0x05; LDI B,0xFB; ADD A,B -> A=0x00, Carry=1; then ADC A,A -> A=0x01, Carry=0.
- SEG=0x12, B=0x34, ST A (A=0x5A) with MemReady low for 3 cycles -> WrtMem, AdrOut=0x1234 and DataOut=0x5A held stable 4 cycles; single write.
- A=0, SEG=0x20, B=0x10, JZ A,B -> next fetch at 0x2010; with A=0x01 -> next fetch at PC+1.
- JAL C,B at 0x0100 with C=0x03, B=0x40 -> next fetch 0x0340; C=0x01, B=0x01.
- MOV at 0xFFFF -> Halted=1 after EXEC, no further LdMem; with JZ taken at 0xFFFF -> no halt; LDI at 0xFFFF -> RA unchanged, Halted=1.
- Rst asserted mid-LD wait state -> next cycle all outputs 0, PC=RESET_PC, registers 0.
